// File: rtl/serial_add_sequencer_if.sv
// Word-level handshake bundle for the bit-serial adder: operand request side and result side.
// master drives operands and result acceptance; slave is the sequencer.
interface serial_add_sequencer_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: captures two W-bit operands plus carry-in, adds them LSB-first
// through a 1-bit full adder over W cycles, and presents sum/cout on a valid/ready handshake.
module serial_add_sequencer #(
    parameter int unsigned W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_add_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              fa_s;
    logic              fa_c;

    // Full adder on the current LSBs; logic operators only.
    assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[W-1:1]};
                carry_d = fa_c;
                if (cnt_q == CntW'(W - 1)) begin
                    // Counter holds on the last bit so it never wraps inside an operation.
                    cout_d  = fa_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StRun);
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer (W=8): reset, sums, backpressure, async reset,
// back-to-back throughput and operand isolation.
module tb_serial_add_sequencer;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_add_sequencer_if #(.W(W)) bus ();

    serial_add_sequencer #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Handshake operands at the next edge, then count edges until out_valid (bounded).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb;
        bus.cin      = tc;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        rs = bus.sum;
        rc = bus.cout;
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           busy_cnt;
        int           hs_cyc [2];
        logic [W-1:0] res_sum [2];
        logic         res_cout [2];
        int           nhs;
        int           nres;
        logic         hs;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 8'hAB;
        bus.b         = 8'hCD;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b1;

        // Reset held across edges with in_valid high: must stay idle.
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // 1: 0x3C + 0x5A, busy for exactly 8 cycles.
        bus.in_valid = 1'b1;
        bus.a        = 8'h3C;
        bus.b        = 8'h5A;
        bus.cin      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        busy_cnt = 0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy) busy_cnt++;
            step();
            lat++;
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_sum", 32'(bus.sum), 32'h96);
        check("t1_cout", 32'(bus.cout), 32'd0);
        check("t1_busy_done", 32'(bus.busy), 32'd0);
        step();
        check("t1_back_idle", 32'(bus.in_ready), 32'd1);

        // 2: wraparound and all-ones with carry-in.
        run_op(8'hFF, 8'h01, 1'b0, rs, rc, lat);
        check("t2a_sum", 32'(rs), 32'h00);
        check("t2a_cout", 32'(rc), 32'd1);
        step();
        run_op(8'hFF, 8'hFF, 1'b1, rs, rc, lat);
        check("t2b_sum", 32'(rs), 32'hFF);
        check("t2b_cout", 32'(rc), 32'd1);
        check("t2b_latency", 32'(lat), 32'd8);
        step();

        // 3: backpressure holds result and blocks new input.
        bus.out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b1, rs, rc, lat);
        check("t3_sum", 32'(rs), 32'h47);
        check("t3_cout", 32'(rc), 32'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_sum", 32'(bus.sum), 32'h47);
            check("t3_hold_cout", 32'(bus.cout), 32'd0);
            check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("t3_release_idle", 32'(bus.in_ready), 32'd1);
        check("t3_release_valid", 32'(bus.out_valid), 32'd0);

        // 4: asynchronous reset in the 3rd RUN cycle.
        bus.in_valid = 1'b1;
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
        bus.cin      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("t4_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_async_busy", 32'(bus.busy), 32'd0);
        check("t4_async_in_ready", 32'(bus.in_ready), 32'd1);
        check("t4_async_sum", 32'(bus.sum), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("t4_no_partial", 32'(bus.out_valid), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, rs, rc, lat);
        check("t4_sum", 32'(rs), 32'h02);
        check("t4_cout", 32'(rc), 32'd0);
        step();

        // 5: back-to-back with in_valid and out_ready held high.
        bus.a        = 8'h80;
        bus.b        = 8'h80;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        nhs  = 0;
        nres = 0;
        hs_cyc[0] = 0;
        hs_cyc[1] = 0;
        for (int c = 0; c < 40 && nres < 2; c++) begin
            hs = bus.in_valid && bus.in_ready;
            step();
            if (hs && nhs < 2) begin
                hs_cyc[nhs] = c;
                nhs++;
                if (nhs == 1) begin
                    bus.a   = 8'h0F;
                    bus.b   = 8'hF0;
                    bus.cin = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                res_sum[nres]  = bus.sum;
                res_cout[nres] = bus.cout;
                nres++;
            end
        end
        bus.in_valid = 1'b0;
        check("t5_results_seen", 32'(nres), 32'd2);
        check("t5_hs_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd10);
        check("t5_r0_sum", 32'(res_sum[0]), 32'h00);
        check("t5_r0_cout", 32'(res_cout[0]), 32'd1);
        check("t5_r1_sum", 32'(res_sum[1]), 32'h00);
        check("t5_r1_cout", 32'(res_cout[1]), 32'd1);
        step();

        // 6: operand inputs toggling during RUN must not disturb the result.
        bus.in_valid = 1'b1;
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.cin      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.a   = 8'($urandom);
            bus.b   = 8'($urandom);
            bus.cin = 1'($urandom);
            step();
            lat++;
        end
        check("t6_latency", 32'(lat), 32'd8);
        check("t6_sum", 32'(bus.sum), 32'h03);
        check("t6_cout", 32'(bus.cout), 32'd0);
        step();
        check("t6_idle", 32'(bus.in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Bit-serial adder controller. It accepts two W-bit operands and a carry-in through a valid/ready handshake, then feeds the operands LSB-first through an internal 1-bit full adder, one bit per cycle. It assembles the W-bit sum and the carry-out and presents them on a valid/ready output handshake. It wraps the serial-adder datapath so that word-level producers and consumers can share it without handling bit timing.

Parameters:
W, 8, operand and sum width in bits; legal range W >= 2.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand request from the producer
in_ready  output  1  sequencer can accept operands
a  input  W  operand A; sampled only on the input handshake
b  input  W  operand B; sampled only on the input handshake
cin  input  1  carry-in; sampled only on the input handshake
out_valid  output  1  result is available
out_ready  input  1  consumer accepts the result
sum  output  W  result, a + b + cin, modulo 2^W
cout  output  1  carry-out of the W-bit addition
busy  output  1  high while in state RUN

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- rst_n low, at any time, including mid-operation:
  - state returns to IDLE immediately, without waiting for a clock edge.
  - All registers clear: operand shift registers, sum register, carry, bit counter, cout.
  - out_valid=0, busy=0, sum=0, cout=0.
  - in_ready=1, because it is decoded from state IDLE.
  - Any in-flight operation is discarded; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE. Outputs are decoded from state only:
  - in_ready = (state==IDLE)
  - busy = (state==RUN)
  - out_valid = (state==DONE)
- IDLE:
  - If in_valid && in_ready at an edge: capture a, b, cin; carry<=cin; cnt<=0; sum register<=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN, one bit per cycle, bit index i=cnt:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0])).
  - The full-adder datapath uses only ^ & | ~; no + operator.
  - Operand registers shift right by one each cycle.
  - The sum register shifts right, with s inserted at bit W-1. After W shifts, bit i holds sum bit i.
  - carry<=carry_next; cnt<=cnt+1.
  - When cnt==W-1: cout<=carry_next and go to DONE.
- RUN lasts exactly W cycles. Counter width is $clog2(W). The counter never wraps within an operation.
- DONE:
  - sum and cout are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready at an edge: go to IDLE. The sum/cout registers keep their value; they are don't-care outside DONE.
- Latency:
  - Input handshake at edge E0 → out_valid=1 after edge E0+W.
  - Minimum period per operation is W+2 cycles (accept, W RUN cycles, output handshake).
- No overlap: in_ready=0 during RUN and DONE. a, b, cin changing outside the handshake have no effect.
- in_valid and out_ready are permitted to be held high continuously. This gives back-to-back operations at W+2 cycles each.
- in_valid asserted during reset is ignored. The first capture is at the first rising edge with rst_n high.
- Width rules: sum is truncated modulo 2^W; the overflow bit is reported only on cout.

Test Plan:
1. W=8: a=0x3C, b=0x5A, cin=0, out_ready=1 → busy for 8 cycles; out_valid after edge E0+8; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. Backpressure: a=0x12, b=0x34, cin=1, out_ready held 0 for 5 cycles after out_valid:
   - out_valid stays 1; sum=0x47 and cout=0 stay stable.
   - in_ready stays 0.
   - Raising out_ready → IDLE on the next edge.
4. Reset mid-RUN: assert rst_n=0 asynchronously on the 3rd RUN cycle of a=0xAA, b=0x55 →
   - immediately: out_valid=0, busy=0, in_ready=1.
   - After release, a=0x01, b=0x01, cin=0 → sum=0x02, cout=0.
5. Back-to-back: in_valid and out_ready held 1 with operand pairs (0x80,0x80,0), (0x0F,0xF0,1) →
   - results (0x00,cout=1) then (0x00,cout=1).
   - Input handshakes spaced exactly 10 cycles apart.
6. Input isolation: change a, b and cin every cycle during RUN of a=0x01, b=0x02, cin=0 → result unaffected: sum=0x03, cout=0.
